// File: rtl/apb_bridge_mslot.sv
// apb_bridge_mslot: single-clock APB3 bridge, one upstream master port (_PM)
// to up to 16 downstream slots (_SC). The slot is decoded from
// PADDR_PM[SEL_LSB+3:SEL_LSB]. A slot index >= NUM_SLOTS gets an error
// response and never reaches a slot. Per-bridge transfer and error counters
// saturate at 16'hFFFF.
// Optional feature: define APB2APB_WATCHDOG_EN to end an ACCESS phase with
// an error after TIMEOUT cycles without PREADY_SC.
// TPD is kept only so old instantiations still elaborate. This RTL applies
// no delays.
module apb_bridge_mslot #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 16,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 255,
    parameter int TPD        = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL_PM,
    input  logic [ADDR_WIDTH-1:0] PADDR_PM,
    input  logic                  PWRITE_PM,
    input  logic                  PENABLE_PM,
    input  logic [DATA_WIDTH-1:0] PWDATA_PM,
    output logic [DATA_WIDTH-1:0] PRDATA_PM,
    output logic                  PREADY_PM,
    output logic                  PSLVERR_PM,
    output logic [NUM_SLOTS-1:0]  PSEL_SC,
    output logic [ADDR_WIDTH-1:0] PADDR_SC,
    output logic                  PWRITE_SC,
    output logic                  PENABLE_SC,
    output logic [DATA_WIDTH-1:0] PWDATA_SC,
    input  logic [DATA_WIDTH-1:0] PRDATA_SC,
    input  logic                  PREADY_SC,
    input  logic                  PSLVERR_SC,
    output logic [15:0]           XFER_CNT,
    output logic [15:0]           ERR_CNT
);

    // An illegal parameter set elaborates this marker block. Legal sets never do.
    if (SEL_LSB + 3 >= ADDR_WIDTH || NUM_SLOTS < 1 || NUM_SLOTS > 16 ||
        TIMEOUT < 1 || TIMEOUT > 65535 || TPD < 0) begin : g_bad_cfg
        logic cfg_illegal;
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state_q;
    logic                   busy_q;     // current PM access phase already taken
    logic                   start_q;    // access captured, decode on next edge
    logic [3:0]             idx_q;
    logic [ADDR_WIDTH-1:0]  addr_l;
    logic [DATA_WIDTH-1:0]  wdata_l;
    logic                   write_l;
    logic                   mapped;

    logic [NUM_SLOTS-1:0]   psel_q;
    logic                   penable_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic                   pwrite_q;
    logic                   pready_q;
    logic                   pslverr_q;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic [15:0]            xfer_q;
    logic [15:0]            err_q;
`ifdef APB2APB_WATCHDOG_EN
    logic [15:0]            wd_cnt;
`endif

    assign mapped = ({1'b0, idx_q} < 5'(NUM_SLOTS));

    assign PSEL_SC    = psel_q;
    assign PENABLE_SC = penable_q;
    assign PADDR_SC   = paddr_q;
    assign PWDATA_SC  = pwdata_q;
    assign PWRITE_SC  = pwrite_q;
    assign PREADY_PM  = pready_q;
    assign PSLVERR_PM = pslverr_q;
    assign PRDATA_PM  = prdata_q;
    assign XFER_CNT   = xfer_q;
    assign ERR_CNT    = err_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    // Bridge FSM. All outputs are registered and change with the state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            idx_q     <= '0;
            addr_l    <= '0;
            wdata_l   <= '0;
            write_l   <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            xfer_q    <= '0;
            err_q     <= '0;
`ifdef APB2APB_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!start_q && !busy_q && PSEL_PM && PENABLE_PM) begin
                        addr_l  <= PADDR_PM;
                        wdata_l <= PWDATA_PM;
                        write_l <= PWRITE_PM;
                        idx_q   <= PADDR_PM[SEL_LSB+3:SEL_LSB];
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end else if (!start_q && !PENABLE_PM) begin
                        busy_q  <= 1'b0;
                    end
                    if (start_q) begin
                        start_q <= 1'b0;
                        if (mapped) begin
                            state_q  <= SETUP;
                            psel_q   <= NUM_SLOTS'(1) << idx_q;
                            paddr_q  <= addr_l;
                            pwdata_q <= wdata_l;
                            pwrite_q <= write_l;
                        end else begin
                            // unmapped slot: answer locally with an error
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                            xfer_q    <= sat_inc(xfer_q, 1'b1);
                            err_q     <= sat_inc(err_q, 1'b1);
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB2APB_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY_SC) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= PSLVERR_SC;
                        prdata_q  <= pwrite_q ? '0 : PRDATA_SC;
                        xfer_q    <= sat_inc(xfer_q, 1'b1);
                        err_q     <= sat_inc(err_q, PSLVERR_SC);
                        state_q   <= RESP;
                    end
`ifdef APB2APB_WATCHDOG_EN
                    else if (wd_cnt == 16'(TIMEOUT - 1)) begin
                        // the slot has been stalled for TIMEOUT cycles: abandon it
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        xfer_q    <= sat_inc(xfer_q, 1'b1);
                        err_q     <= sat_inc(err_q, 1'b1);
                        state_q   <= RESP;
                    end else begin
                        wd_cnt    <= wd_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    paddr_q   <= '0;
                    pwdata_q  <= '0;
                    pwrite_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
